// File: rtl/uart_rx_os16.sv
// ---------------------------------------------------------------------------
// uart_rx_os16
//
// UART receiver (8N1 by default) using 16x oversampling. It sits directly
// downstream of the UART clock generator and takes that block's rxclk square
// wave (16x baud, synchronous to clk). Each rxclk rising edge becomes a
// one-clk sample tick, and the receive state machine only advances on ticks.
//
// Ports:
//   clk       in   system (master) clock
//   rst       in   synchronous, active-high reset
//   rxclk     in   16x-baud square wave from the clock generator
//   rx        in   asynchronous serial line, idle high
//   rx_data   out  last correctly framed byte, held until the next good frame
//   rx_valid  out  one-clk pulse when rx_data updates
//   frame_err out  one-clk pulse when a stop bit is sampled low
//   busy      out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int MID   = OVERSAMPLE / 2 - 1;

  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(MID);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic                 rxMeta_q;
  logic                 rxSync_q;
  logic                 rxclkQ1_q;
  logic                 rxclkQ2_q;
  logic                 tick;

  state_e               state_q;
  logic [OS_W-1:0]      osCnt_q;
  logic [BIT_W-1:0]     bitCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rxData_q;
  logic                 rxValid_q;
  logic                 frameErr_q;

  // Input conditioning: a two-flop synchroniser for the asynchronous serial
  // line, and a two-stage register on rxclk for rising-edge detection. All
  // four flops reset high, so an idle-high line does not look like a start
  // bit and an rxclk that is already high at release does not fire a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxclkQ1_q <= 1'b1;
      rxclkQ2_q <= 1'b1;
    end else begin
      rxMeta_q  <= rx;
      rxSync_q  <= rxMeta_q;
      rxclkQ1_q <= rxclk;
      rxclkQ2_q <= rxclkQ1_q;
    end
  end

  // Exactly one clk high per rxclk rising edge.
  assign tick = rxclkQ1_q & ~rxclkQ2_q;

  // Receive state machine. Everything advances on ticks only, except the
  // output pulses, which are cleared every clk so they last exactly one clk.
  // The start bit is re-checked at mid-bit to reject glitches; data and stop
  // bits are then sampled every 16 ticks from that mid-bit point. STOP
  // hands back to IDLE at mid-stop-bit so a back-to-back start edge is seen.
  // A low stop bit parks the FSM in BREAK until the line goes high again, so
  // a held-low line cannot re-trigger frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      osCnt_q    <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxSync_q) begin
              state_q <= S_START;
              osCnt_q <= '0;
            end
          end
          S_START: begin
            if (osCnt_q != OS_MID) begin
              osCnt_q <= osCnt_q + OS_W'(1);
            end else if (!rxSync_q) begin
              state_q  <= S_DATA;
              osCnt_q  <= '0;
              bitCnt_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_DATA: begin
            if (osCnt_q != OS_LAST) begin
              osCnt_q <= osCnt_q + OS_W'(1);
            end else begin
              // LSB arrives first, so shift in from the top.
              shift_q <= {rxSync_q, shift_q[DATA_BITS-1:1]};
              osCnt_q <= '0;
              if (bitCnt_q == BIT_LAST) begin
                state_q <= S_STOP;
              end else begin
                bitCnt_q <= bitCnt_q + BIT_W'(1);
              end
            end
          end
          S_STOP: begin
            if (osCnt_q != OS_LAST) begin
              osCnt_q <= osCnt_q + OS_W'(1);
            end else if (rxSync_q) begin
              rxData_q  <= shift_q;
              rxValid_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= S_BREAK;
            end
          end
          S_BREAK: begin
            if (rxSync_q) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os16
//
// Self-checking bench for uart_rx_os16. rxclk runs at 13 clk per period, so
// one bit time is 16 * 13 = 208 clk. Each frame sent pushes its expected
// outcome (good byte or framing error, plus the rx_data value that should be
// visible) into a queue; a monitor on the falling clock edge pops and checks
// whenever the DUT pulses rx_valid or frame_err.
// ---------------------------------------------------------------------------
module tb_uart_rx_os16;

  localparam int RXCLK_PER = 13;
  localparam int BIT       = 16 * RXCLK_PER;
  // Pulse lands 152 ticks after the detect tick; detect is 3..15 clk after
  // the line falls (synchroniser plus waiting for the next tick).
  localparam int LAT_MIN   = 152 * RXCLK_PER + 2;
  localparam int LAT_MAX   = 152 * RXCLK_PER + 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxclk = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cycCnt = 0;
  bit rxclkRun = 1'b0;
  int ph = 0;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
    int         startCyc;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] lastGood = 8'h00;
  exp_t       monE;
  int         monLat;

  uart_rx_os16 dut (
    .clk       (clk),
    .rst       (rst),
    .rxclk     (rxclk),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Master clock and a running edge count used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  // rxclk generator: 6 clk high, 7 clk low, aligned to clk.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rxclkRun) begin
        rxclk = (ph < 6);
        ph    = (ph + 1) % RXCLK_PER;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycCnt);
    end
  endtask

  // Hold the serial line at a level for n clk; always leaves us #1 after a
  // rising edge.
  task automatic holdRx(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one frame: start bit, 8 data bits LSB first, stop bit. A low stop
  // bit is followed by extraLow further low bit times and one high bit time.
  task automatic applyStimulus(input logic [7:0] d, input bit stopBit, input int extraLow);
    exp_t e;
    e.isErr    = !stopBit;
    e.data     = stopBit ? d : lastGood;
    e.startCyc = cycCnt;
    if (stopBit) lastGood = d;
    expQ.push_back(e);
    holdRx(1'b0, BIT);
    for (int i = 0; i < 8; i++) holdRx(d[i], BIT);
    holdRx(stopBit, BIT);
    if (!stopBit) begin
      for (int k = 0; k < extraLow; k++) begin
        holdRx(1'b0, BIT / 2);
        checkOutput("busy_in_break", busy, 1);
        holdRx(1'b0, BIT - BIT / 2);
      end
      holdRx(1'b1, BIT);
    end
    checkOutput("busy_after_frame", busy, 0);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest pending
  // expectation in kind, data, busy level and arrival time.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      checkOutput("pulse_exclusive", int'(rx_valid && frame_err), 0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {31'd0, frame_err}, {31'd0, ~frame_err});
      end else begin
        monE   = expQ.pop_front();
        monLat = cycCnt - monE.startCyc;
        checkOutput("pulse_is_ferr", frame_err, monE.isErr);
        checkOutput("rx_data", rx_data, monE.data);
        checkOutput("busy_at_pulse", busy, monE.isErr);
        if (monLat < LAT_MIN || monLat > LAT_MAX)
          checkOutput("pulse_latency", monLat, LAT_MIN);
        else
          checkOutput("pulse_latency", monLat, monLat);
      end
    end
  end

  initial begin
    logic [9:0] partial;
    logic [7:0] rd;
    bit         rs;
    int         gap;

    // Reset with rxclk toggling, ending high so release must not tick.
    rst = 1'b1;
    rx  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxclk = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("no_tick_after_release", dut.tick, 0);
    end
    @(posedge clk);
    #1;
    rxclkRun = 1'b1;
    holdRx(1'b1, 100);

    // Single good frame.
    applyStimulus(8'hA5, 1'b1, 0);
    holdRx(1'b1, 50);

    // Glitch: 4 ticks low, then high again.
    holdRx(1'b0, 30);
    checkOutput("glitch_busy_early", busy, 1);
    holdRx(1'b0, 22);
    holdRx(1'b1, 48);
    checkOutput("glitch_busy_start", busy, 1);
    holdRx(1'b1, 40);
    checkOutput("glitch_busy_done", busy, 0);
    checkOutput("glitch_rx_data", rx_data, lastGood);
    holdRx(1'b1, 100);

    // Framing error followed by a three-bit-time break.
    applyStimulus(8'h3C, 1'b0, 3);
    checkOutput("ferr_rx_data_kept", rx_data, 8'hA5);
    holdRx(1'b1, 50);

    // Back-to-back frames with no idle gap.
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    applyStimulus(8'h81, 1'b1, 0);
    holdRx(1'b1, 50);

    // Reset about 60 ticks into a 0x55 frame.
    partial = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 60 * RXCLK_PER; c++) begin
      rx = partial[c / BIT];
      @(posedge clk);
      #1;
    end
    checkOutput("midframe_busy_before", busy, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    lastGood = 8'h00;
    checkOutput("midframe_busy_after_rst", busy, 0);
    checkOutput("midframe_rx_data", rx_data, 0);
    checkOutput("midframe_no_valid", rx_valid, 0);
    checkOutput("midframe_no_ferr", frame_err, 0);
    rst = 1'b0;
    holdRx(1'b1, BIT);
    applyStimulus(8'hC3, 1'b1, 0);

    // Random frames: random data, mostly good stop bits, random gaps.
    for (int n = 0; n < 10; n++) begin
      gap = $urandom_range(0, 300);
      if (gap > 0) holdRx(1'b1, gap);
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus(rd, rs, rs ? 0 : int'($urandom_range(0, 2)));
    end

    // Let any outstanding pulse arrive, bounded.
    for (int i = 0; i < 4000 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("queue_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
